mack_bus_controller: RTL and testbench

- Parametrised second-generation bus controller for the 68000 board.
- Replaces the fixed ROM/RAM/DUART decoder with NUM_CS mask/base-matched chip selects, a configurable boot ROM overlay, and per-region internal DTACK wait-state generation.
- Adds a bus-error watchdog, a periodic timer interrupt, and a level-qualified autovector (VPA) response.
- Sits between the CPU bus strobes and all memory/peripheral enables.

---
 rtl/mack_bus_pkg.sv | 40 ++++
 rtl/mack_bus_controller_timer.sv | 78 +++++++
 rtl/mack_bus_controller.sv | 185 ++++++++++++++++++
 tb/tb_mack_bus_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mack_bus_pkg.sv
// -----------------------------------------------------------------------------
// mack_bus_pkg
// Shared definitions for the second-generation 68000 bus controller:
//   - chip-select region indices (lower index = higher decode priority)
//   - default base/mask pairs for the stock ROM / DUART / RAM map
//   - default interrupt level serviced by the on-chip periodic timer
//   - DTACK source selector used by the top-level acknowledge mux
//   - address/region compare helper
// -----------------------------------------------------------------------------
package mack_bus_pkg;

  localparam int CS_ROM   = 0;
  localparam int CS_DUART = 1;
  localparam int CS_RAM   = 2;

  localparam logic [7:0] ROM_BASE   = 8'h38;
  localparam logic [7:0] ROM_MASK   = 8'hFC;
  localparam logic [7:0] DUART_BASE = 8'h3C;
  localparam logic [7:0] DUART_MASK = 8'hFC;
  localparam logic [7:0] RAM_BASE   = 8'h00;
  localparam logic [7:0] RAM_MASK   = 8'h00;

  localparam logic [2:0] TIMER_LEVEL_DEFAULT = 3'd5;

  // Where the acknowledge for the current bus cycle comes from.
  typedef enum logic [1:0] {
    DT_NONE     = 2'd0,  // idle, unmapped or reset: DTACK stays high
    DT_INTERNAL = 2'd1,  // wait-state counter of the selected region
    DT_EXTERNAL = 2'd2,  // passed through from DTACK_IN
    DT_AUTOVEC  = 2'd3   // VPA answers this IACK cycle instead of DTACK
  } dtack_src_e;

  // A region matches when the masked address equals its base.
  function automatic logic region_match(input logic [7:0] addr,
                                        input logic [7:0] base,
                                        input logic [7:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mack_bus_controller_timer.sv
// -----------------------------------------------------------------------------
// mack_periodic_timer
// Free-running 2^TIMER_BITS cycle timer with a sticky pending flag and the
// autovector hold that keeps VPA asserted once the acknowledge has consumed
// the pending request.
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous reset, active-low
//   AS         in   address strobe, active-low
//   IACK       in   interrupt-acknowledge cycle, active-low
//   IACK_LVL   in   [2:0] level being acknowledged
//   TIMER_IRQ  out  interrupt request, active-low (inactive in reset)
//   vpa_req    out  active-high autovector request for this level
// -----------------------------------------------------------------------------
module mack_periodic_timer
  import mack_bus_pkg::*;
#(
  parameter int         TIMER_BITS  = 16,
  parameter logic [2:0] TIMER_LEVEL = TIMER_LEVEL_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS,
  input  logic       IACK,
  input  logic [2:0] IACK_LVL,
  output logic       TIMER_IRQ,
  output logic       vpa_req
);

  logic [TIMER_BITS-1:0] count_q, count_d;
  logic                  pending_q, pending_d;
  logic                  vpa_hold_q, vpa_hold_d;
  logic                  level_hit;
  logic                  wrap;
  logic                  ack;

  assign level_hit = ~AS & ~IACK & (IACK_LVL == TIMER_LEVEL);
  assign wrap      = &count_q;
  assign ack       = level_hit & pending_q;

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    count_d    = count_q + 1'b1;
    pending_d  = pending_q;
    vpa_hold_d = vpa_hold_q;
    // A wrap wins over a simultaneous acknowledge so no tick is lost.
    if (wrap) begin
      pending_d = 1'b1;
    end else if (ack) begin
      pending_d = 1'b0;
    end
    if (AS) begin
      vpa_hold_d = 1'b0;
    end else if (ack) begin
      vpa_hold_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      count_q    <= '0;
      pending_q  <= 1'b0;
      vpa_hold_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      pending_q  <= pending_d;
      vpa_hold_q <= vpa_hold_d;
    end
  end

  assign TIMER_IRQ = ~(pending_q & RST);
  // The hold keeps VPA steady for the rest of the cycle after the ack edge.
  assign vpa_req   = level_hit & (pending_q | vpa_hold_q);

endmodule

// File: rtl/mack_bus_controller.sv
// -----------------------------------------------------------------------------
// mack_bus_controller
// 68000 bus controller: mask/base chip selects with a boot ROM overlay,
// per-region internal wait states or external DTACK, bus-error watchdog and
// a periodic timer interrupt answered by autovector.
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous reset, active-low
//   ADDR       in   [7:0] CPU A[23:16]
//   IACK_LVL   in   [2:0] CPU A[3:1] during an IACK cycle
//   AS         in   address strobe, active-low
//   IACK       in   interrupt-acknowledge cycle, active-low
//   DTACK_IN   in   external DTACK, active-low
//   CS_N       out  [NUM_CS-1:0] chip selects, active-low
//   DTACK      out  DTACK to CPU, active-low
//   VPA        out  autovector request, active-low
//   BERR       out  bus error, active-low
//   TIMER_IRQ  out  timer interrupt request, active-low
//   BOOT_DONE  out  high once the boot overlay has ended
// -----------------------------------------------------------------------------
module mack_bus_controller
  import mack_bus_pkg::*;
#(
  parameter int                        NUM_CS       = 3,
  parameter logic [NUM_CS*8-1:0]       CS_BASE      = {RAM_BASE, DUART_BASE, ROM_BASE},
  parameter logic [NUM_CS*8-1:0]       CS_MASK      = {RAM_MASK, DUART_MASK, ROM_MASK},
  parameter int                        WAIT_W       = 3,
  parameter logic [NUM_CS*WAIT_W-1:0]  CS_WAIT      = '0,
  parameter logic [NUM_CS-1:0]         CS_EXT       = 3'b010,
  parameter int                        BOOT_CYCLES  = 8,
  parameter int                        BERR_TIMEOUT = 64,
  parameter int                        TIMER_BITS   = 16,
  parameter logic [2:0]                TIMER_LEVEL  = TIMER_LEVEL_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        ADDR,
  input  logic [2:0]        IACK_LVL,
  input  logic              AS,
  input  logic              IACK,
  input  logic              DTACK_IN,
  output logic [NUM_CS-1:0] CS_N,
  output logic              DTACK,
  output logic              VPA,
  output logic              BERR,
  output logic              TIMER_IRQ,
  output logic              BOOT_DONE
);

  localparam int WCNT_W = $clog2(BERR_TIMEOUT + 1);
  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(BERR_TIMEOUT);
  localparam logic [BOOT_W-1:0] BOOT_MAX = BOOT_W'(BOOT_CYCLES);

  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic              boot_done_q, boot_done_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic              bus_active;
  logic              cs_active;
  logic [NUM_CS-1:0] sel_oh;
  logic              ext_sel;
  logic [WAIT_W-1:0] wait_sel;
  logic              vpa_req;
  logic              dtack_n;
  logic              vpa_n;
  dtack_src_e        dtack_src;

  // ---------------------------------------------------------------------------
  // Boot overlay count and wait-state counter. The wait counter is 0 exactly
  // on the first AS-low edge of a bus cycle, which doubles as the "count this
  // cycle once" qualifier for the boot counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    boot_cnt_d  = boot_cnt_q;
    boot_done_d = boot_done_q;
    wait_cnt_d  = wait_cnt_q;
    if (AS) begin
      wait_cnt_d = '0;
      if (boot_cnt_q >= BOOT_MAX) begin
        boot_done_d = 1'b1;
      end
    end else begin
      if (wait_cnt_q != WCNT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if ((wait_cnt_q == '0) && (boot_cnt_q != BOOT_MAX)) begin
        boot_cnt_d = boot_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      boot_cnt_q  <= '0;
      boot_done_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      boot_cnt_q  <= boot_cnt_d;
      boot_done_q <= boot_done_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Region decode: lowest matching index wins; the overlay forces the ROM.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if ((sel_oh == '0) && region_match(ADDR, CS_BASE[i*8 +: 8], CS_MASK[i*8 +: 8])) begin
        sel_oh[i] = 1'b1;
      end
    end
    if (!boot_done_q) begin
      sel_oh         = '0;
      sel_oh[CS_ROM] = 1'b1;
    end
  end

  always_comb begin
    ext_sel  = 1'b0;
    wait_sel = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel_oh[i]) begin
        ext_sel  = CS_EXT[i];
        wait_sel = CS_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

  assign bus_active = RST & ~AS;
  assign cs_active  = bus_active & IACK;
  assign CS_N       = ~(sel_oh & {NUM_CS{cs_active}});

  // ---------------------------------------------------------------------------
  // Periodic timer and autovector request.
  // ---------------------------------------------------------------------------
  mack_periodic_timer #(
    .TIMER_BITS  (TIMER_BITS),
    .TIMER_LEVEL (TIMER_LEVEL)
  ) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .AS        (AS),
    .IACK      (IACK),
    .IACK_LVL  (IACK_LVL),
    .TIMER_IRQ (TIMER_IRQ),
    .vpa_req   (vpa_req)
  );

  assign vpa_n = ~(bus_active & vpa_req);

  // ---------------------------------------------------------------------------
  // Acknowledge source. An IACK cycle the timer does not claim (other level,
  // or spurious at its own level) falls through to the external device.
  // ---------------------------------------------------------------------------
  always_comb begin
    dtack_src = DT_NONE;
    if (bus_active) begin
      if (!IACK) begin
        dtack_src = vpa_req ? DT_AUTOVEC : DT_EXTERNAL;
      end else if (sel_oh != '0) begin
        dtack_src = ext_sel ? DT_EXTERNAL : DT_INTERNAL;
      end
    end
  end

  always_comb begin
    dtack_n = 1'b1;
    case (dtack_src)
      DT_INTERNAL: dtack_n = ~(wait_cnt_q >= WCNT_W'(wait_sel));
      DT_EXTERNAL: dtack_n = DTACK_IN;
      DT_AUTOVEC:  dtack_n = 1'b1;
      default:     dtack_n = 1'b1;
    endcase
  end

  assign DTACK = dtack_n;
  assign VPA   = vpa_n;
  // Saturated counter keeps BERR asserted until AS rises.
  assign BERR  = ~(bus_active & (wait_cnt_q == WCNT_MAX) & dtack_n & vpa_n);
  assign BOOT_DONE = boot_done_q & RST;

endmodule

// File: tb/tb_mack_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_mack_bus_controller
// Three controllers share one stimulus: u_def (defaults), u_alt (RAM with
// three wait states, 4-bit timer) and u_two (two regions, RAM removed).
// A rule-level model predicts every output of all three on each cycle; the
// directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mack_bus_controller;

  logic       CLK;
  logic       RST;
  logic [7:0] ADDR;
  logic [2:0] IACK_LVL;
  logic       AS;
  logic       IACK;
  logic       DTACK_IN;

  logic [2:0] def_cs_n, alt_cs_n;
  logic [1:0] two_cs_n;
  logic def_dtack, def_vpa, def_berr, def_irq, def_bd;
  logic alt_dtack, alt_vpa, alt_berr, alt_irq, alt_bd;
  logic two_dtack, two_vpa, two_berr, two_irq, two_bd;

  int n_checks = 0;
  int n_errors = 0;
  int edges = 0;
  bit cmp_en = 1'b0;

  mack_bus_controller u_def (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .IACK_LVL(IACK_LVL), .AS(AS), .IACK(IACK),
    .DTACK_IN(DTACK_IN), .CS_N(def_cs_n), .DTACK(def_dtack), .VPA(def_vpa),
    .BERR(def_berr), .TIMER_IRQ(def_irq), .BOOT_DONE(def_bd)
  );

  mack_bus_controller #(
    .CS_WAIT    (9'b011_000_000),
    .TIMER_BITS (4)
  ) u_alt (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .IACK_LVL(IACK_LVL), .AS(AS), .IACK(IACK),
    .DTACK_IN(DTACK_IN), .CS_N(alt_cs_n), .DTACK(alt_dtack), .VPA(alt_vpa),
    .BERR(alt_berr), .TIMER_IRQ(alt_irq), .BOOT_DONE(alt_bd)
  );

  mack_bus_controller #(
    .NUM_CS  (2),
    .CS_BASE (16'h3C38),
    .CS_MASK (16'hFCFC),
    .CS_WAIT (6'b000_000),
    .CS_EXT  (2'b10)
  ) u_two (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .IACK_LVL(IACK_LVL), .AS(AS), .IACK(IACK),
    .DTACK_IN(DTACK_IN), .CS_N(two_cs_n), .DTACK(two_dtack), .VPA(two_vpa),
    .BERR(two_berr), .TIMER_IRQ(two_irq), .BOOT_DONE(two_bd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!RST) edges <= 0;
    else      edges <= edges + 1;
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: bus-cycle bookkeeping plus two timers (16-bit for
  // u_def/u_two, 4-bit for u_alt).
  // ---------------------------------------------------------------------------
  int unsigned m_boot_cnt, m_wcnt;
  bit          m_in_cyc, m_boot_done;
  int unsigned m_tmr [2];
  bit          m_pend [2];
  bit          m_vhold [2];
  wire         lvl_hit = !AS && !IACK && (IACK_LVL == 3'd5);

  function automatic int unsigned tmax(input int t);
    return (t == 0) ? 32'd65535 : 32'd15;
  endfunction

  always @(posedge CLK) begin
    if (!RST) begin
      m_boot_cnt  <= 0;
      m_wcnt      <= 0;
      m_in_cyc    <= 1'b0;
      m_boot_done <= 1'b0;
      for (int t = 0; t < 2; t++) begin
        m_tmr[t]   <= 0;
        m_pend[t]  <= 1'b0;
        m_vhold[t] <= 1'b0;
      end
    end else begin
      for (int t = 0; t < 2; t++) begin
        m_tmr[t]   <= (m_tmr[t] == tmax(t)) ? 0 : m_tmr[t] + 1;
        m_pend[t]  <= (m_tmr[t] == tmax(t)) ? 1'b1 : (m_pend[t] && !lvl_hit);
        m_vhold[t] <= AS ? 1'b0 : (m_vhold[t] || (lvl_hit && m_pend[t]));
      end
      if (!AS) begin
        if (!m_in_cyc && m_boot_cnt < 8) m_boot_cnt <= m_boot_cnt + 1;
        m_in_cyc <= 1'b1;
        m_wcnt   <= (m_wcnt < 64) ? m_wcnt + 1 : 64;
      end else begin
        m_in_cyc <= 1'b0;
        m_wcnt   <= 0;
        if (m_boot_cnt >= 8) m_boot_done <= 1'b1;
      end
    end
  end

  // Returns {cs_n[2:0], dtack, vpa, berr, irq, boot_done}; k: 0 def, 1 alt, 2 two.
  function automatic logic [7:0] predict(input int k);
    logic [7:0] base [3];
    logic [7:0] mask [3];
    int         ncs;
    int         ti;
    int         sel;
    int unsigned wt;
    logic [2:0] cs_n;
    logic       dt, vpa, berr, irq;
    base = '{8'h38, 8'h3C, 8'h00};
    mask = '{8'hFC, 8'hFC, 8'h00};
    ncs  = (k == 2) ? 2 : 3;
    ti   = (k == 1) ? 1 : 0;
    sel  = -1;
    cs_n = 3'b111;
    dt   = 1'b1;
    if (!RST) return 8'b1111_1110;
    vpa = !(lvl_hit && (m_pend[ti] || m_vhold[ti]));
    if (!AS && IACK) begin
      if (!m_boot_done) sel = 0;
      else begin
        for (int i = 0; i < ncs; i++)
          if (sel < 0 && (ADDR & mask[i]) == base[i]) sel = i;
      end
    end
    if (sel >= 0) cs_n[sel] = 1'b0;
    if (!AS) begin
      if (!IACK) dt = !vpa ? 1'b1 : DTACK_IN;
      else if (sel == 1) dt = DTACK_IN;
      else if (sel >= 0) begin
        wt = (k == 1 && sel == 2) ? 3 : 0;
        dt = !(m_wcnt >= wt);
      end
    end
    berr = !(!AS && m_wcnt == 64 && dt && vpa);
    irq  = !m_pend[ti];
    return {cs_n, dt, vpa, berr, irq, m_boot_done};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model u_def", {def_cs_n, def_dtack, def_vpa, def_berr, def_irq, def_bd}, predict(0));
      check("model u_alt", {alt_cs_n, alt_dtack, alt_vpa, alt_berr, alt_irq, alt_bd}, predict(1));
      check("model u_two", {1'b1, two_cs_n, two_dtack, two_vpa, two_berr, two_irq, two_bd}, predict(2));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 ns after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_bus(input logic as_n, input logic iack_n, input logic [2:0] lvl,
                         input logic [7:0] addr, input logic dtin);
    AS = as_n; IACK = iack_n; IACK_LVL = lvl; ADDR = addr; DTACK_IN = dtin;
  endtask

  initial begin
    RST = 1'b0;
    set_bus(1'b0, 1'b1, 3'd0, 8'h00, 1'b1);
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    // Reset with AS low: everything inactive.
    check("rst cs_n",      {5'b0, def_cs_n}, 8'h07);
    check("rst dtack",     {7'b0, def_dtack}, 8'h01);
    check("rst vpa",       {7'b0, def_vpa}, 8'h01);
    check("rst berr",      {7'b0, def_berr}, 8'h01);
    check("rst irq",       {7'b0, def_irq}, 8'h01);
    check("rst boot_done", {7'b0, def_bd}, 8'h00);
    set_bus(1'b1, 1'b1, 3'd0, 8'h00, 1'b1);
    RST = 1'b1;
    tick();

    // Boot overlay: 8 cycles to ROM, the 9th decodes normally (RAM).
    for (int c = 1; c <= 9; c++) begin
      set_bus(1'b0, 1'b1, 3'd0, 8'h00, 1'b1);
      #1;
      check("boot cs_n", {5'b0, def_cs_n}, (c <= 8) ? 8'h06 : 8'h03);
      if (c == 1) check("boot dtack", {7'b0, def_dtack}, 8'h00);
      tick();
      tick();
      AS = 1'b1;
      #1;
      if (c == 8) check("boot_done before", {7'b0, def_bd}, 8'h00);
      tick();
      if (c == 8) check("boot_done after", {7'b0, def_bd}, 8'h01);
    end

    // Normal decode: ROM vs DUART, DTACK_IN only for the DUART.
    set_bus(1'b0, 1'b1, 3'd0, 8'h3A, 1'b1);
    #1;
    check("rom cs_n", {5'b0, def_cs_n}, 8'h06);
    check("rom dtack", {7'b0, def_dtack}, 8'h00);
    tick();
    set_bus(1'b1, 1'b1, 3'd0, 8'h3A, 1'b1);
    tick();
    set_bus(1'b0, 1'b1, 3'd0, 8'h3D, 1'b1);
    #1;
    check("duart cs_n", {5'b0, def_cs_n}, 8'h05);
    check("duart dtack hi", {7'b0, def_dtack}, 8'h01);
    DTACK_IN = 1'b0;
    #1;
    check("duart dtack lo", {7'b0, def_dtack}, 8'h00);
    tick();
    set_bus(1'b1, 1'b1, 3'd0, 8'h3D, 1'b1);
    tick();

    // RAM with three wait states on u_alt.
    set_bus(1'b0, 1'b1, 3'd0, 8'h10, 1'b1);
    #1;
    check("wait edge0", {7'b0, alt_dtack}, 8'h01);
    check("wait def", {7'b0, def_dtack}, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("wait edgeN", {7'b0, alt_dtack}, (k >= 3) ? 8'h00 : 8'h01);
    end
    AS = 1'b1;
    #1;
    check("wait release", {7'b0, alt_dtack}, 8'h01);
    tick();

    // Unmapped access on u_two: bus error at count 64.
    set_bus(1'b0, 1'b1, 3'd0, 8'h00, 1'b1);
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (k == 63) check("berr 63", {7'b0, two_berr}, 8'h01);
      if (k == 64) check("berr 64", {7'b0, two_berr}, 8'h00);
    end
    check("berr def none", {7'b0, def_berr}, 8'h01);
    AS = 1'b1;
    #1;
    check("berr release", {7'b0, two_berr}, 8'h01);
    tick();

    // First 16-bit timer wrap.
    while (edges < 65535) tick();
    check("irq before wrap", {7'b0, def_irq}, 8'h01);
    tick();
    check("irq after wrap", {7'b0, def_irq}, 8'h00);

    // Autovectored IACK at the timer level.
    set_bus(1'b0, 1'b0, 3'd5, 8'hFF, 1'b1);
    #1;
    check("iack5 vpa", {7'b0, def_vpa}, 8'h00);
    check("iack5 dtack", {7'b0, def_dtack}, 8'h01);
    tick();
    check("iack5 vpa hold", {7'b0, def_vpa}, 8'h00);
    check("iack5 irq clr", {7'b0, def_irq}, 8'h01);
    tick();
    check("iack5 vpa hold2", {7'b0, def_vpa}, 8'h00);
    AS = 1'b1; IACK = 1'b1;
    #1;
    check("iack5 vpa end", {7'b0, def_vpa}, 8'h01);
    tick();

    // IACK at another level: DTACK_IN passes, no VPA.
    set_bus(1'b0, 1'b0, 3'd3, 8'hFF, 1'b0);
    #1;
    check("iack3 vpa", {7'b0, def_vpa}, 8'h01);
    check("iack3 dtack lo", {7'b0, def_dtack}, 8'h00);
    DTACK_IN = 1'b1;
    #1;
    check("iack3 dtack hi", {7'b0, def_dtack}, 8'h01);
    tick();
    set_bus(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
    tick();

    // Spurious IACK at the timer level (nothing pending on u_def).
    set_bus(1'b0, 1'b0, 3'd5, 8'hFF, 1'b0);
    #1;
    check("spurious vpa", {7'b0, def_vpa}, 8'h01);
    check("spurious dtack", {7'b0, def_dtack}, 8'h00);
    tick();
    set_bus(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
    tick();

    // Ack coincident with a wrap on the 4-bit timer of u_alt.
    for (int k = 0; k < 20; k++) tick();
    while ((edges % 16) != 15) tick();
    check("coinc irq pre", {7'b0, alt_irq}, 8'h00);
    set_bus(1'b0, 1'b0, 3'd5, 8'hFF, 1'b1);
    #1;
    check("coinc vpa", {7'b0, alt_vpa}, 8'h00);
    tick();
    check("coinc irq", {7'b0, alt_irq}, 8'h00);
    check("coinc vpa hold", {7'b0, alt_vpa}, 8'h00);
    set_bus(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
    tick();
    check("coinc irq kept", {7'b0, alt_irq}, 8'h00);
    set_bus(1'b0, 1'b0, 3'd5, 8'hFF, 1'b1);
    tick();
    check("late ack irq", {7'b0, alt_irq}, 8'h01);
    set_bus(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
    tick();

    // Reset in the middle of a bus cycle.
    set_bus(1'b0, 1'b1, 3'd0, 8'h3A, 1'b1);
    tick();
    RST = 1'b0;
    #1;
    check("mid rst cs_n", {5'b0, def_cs_n}, 8'h07);
    check("mid rst dtack", {7'b0, def_dtack}, 8'h01);
    check("mid rst vpa", {7'b0, def_vpa}, 8'h01);
    check("mid rst berr", {7'b0, def_berr}, 8'h01);
    check("mid rst irq", {7'b0, alt_irq}, 8'h01);
    check("mid rst boot_done", {7'b0, def_bd}, 8'h00);
    tick();
    tick();
    RST = 1'b1;
    AS = 1'b1;
    tick();
    check("post rst boot_done", {7'b0, def_bd}, 8'h00);
    set_bus(1'b0, 1'b1, 3'd0, 8'h3D, 1'b1);
    #1;
    check("post rst overlay", {5'b0, def_cs_n}, 8'h06);
    tick();
    AS = 1'b1;
    tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
